coin_acceptor: RTL and testbench

- Front-end stage of the vending machine, directly upstream of the 3-state vend FSM.
- Turns a raw, bouncy coin-slot sensor plus a denomination code into clean one-cycle `coin` pulses and a one-cycle `check` pulse, which drive the FSM's `coin`/`check` inputs.
- Keeps the running credit in cents, enforces price and maximum credit, and issues refunds on cancel or after a vend.

---
 rtl/vend_pkg.sv | 35 +++
 rtl/coin_debounce.sv | 46 ++++
 rtl/coin_acceptor.sv | 131 +++++++++++++
 tb/tb_coin_acceptor.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared vending-machine types and constants.
// Coin denominations, state encodings and default pricing.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    COLLECT = 2'b01,
    READY   = 2'b10,
    REFUND  = 2'b11
  } state_t;

  localparam logic [1:0] CODE_INV = 2'b00;
  localparam logic [1:0] CODE_5   = 2'b01;
  localparam logic [1:0] CODE_10  = 2'b10;
  localparam logic [1:0] CODE_25  = 2'b11;

  localparam logic [4:0] CENTS_5  = 5'd5;
  localparam logic [4:0] CENTS_10 = 5'd10;
  localparam logic [4:0] CENTS_25 = 5'd25;

  localparam int DEF_PRICE      = 75;
  localparam int DEF_MAX_CREDIT = 200;

  function automatic logic [4:0] coin_cents(input logic [1:0] code);
    logic [4:0] c;
    case (code)
      CODE_5:  c = CENTS_5;
      CODE_10: c = CENTS_10;
      CODE_25: c = CENTS_25;
      default: c = 5'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// Slot sensor synchronizer and debouncer.
// One registered accept pulse per stable high; re-arms after stable low.
module coin_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic coin_raw,
  output logic accept
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

  logic          s1;
  logic          s2;
  logic          armed;
  logic [CW-1:0] cnt;

  // Armed: count 1s to fire. Disarmed: count 0s to re-arm.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      armed  <= 1'b0;
      cnt    <= '0;
      accept <= 1'b0;
    end else begin
      s1     <= coin_raw;
      s2     <= s1;
      accept <= 1'b0;
      if (s2 == armed) begin
        if (cnt == LAST) begin
          cnt    <= '0;
          armed  <= ~armed;
          accept <= armed;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor front end: debounce, credit, price check, refunds.
// Feeds clean coin/check pulses to the downstream vend FSM.
module coin_acceptor
  import vend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PRICE           = DEF_PRICE,
  parameter int MAX_CREDIT      = DEF_MAX_CREDIT,
  parameter int CREDIT_W        = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_raw,
  input  logic [1:0]          coin_val,
  input  logic                cancel,
  input  logic                vend_done,
  output logic                coin,
  output logic                check,
  output logic                reject,
  output logic [CREDIT_W-1:0] credit,
  output logic                refund,
  output logic [CREDIT_W-1:0] refund_amt
);

  localparam int W = CREDIT_W;
  localparam logic [W:0]   PRICE_X = (W+1)'(PRICE);
  localparam logic [W:0]   MAX_X   = (W+1)'(MAX_CREDIT);
  localparam logic [W-1:0] PRICE_W = W'(PRICE);

  logic         accept;
  state_t       state;
  state_t       state_n;
  logic [W-1:0] credit_n;
  logic [W-1:0] amt_n;
  logic         coin_n;
  logic         check_n;
  logic         reject_n;
  logic         refund_n;
  logic [W:0]   val;
  logic [W:0]   sum;
  logic         ok;

  coin_debounce #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_deb (
    .clk      (clk),
    .rst      (rst),
    .coin_raw (coin_raw),
    .accept   (accept)
  );

  // Extra bit keeps an overflowing sum visible to the ceiling check.
  assign val = (W+1)'(coin_cents(coin_val));
  assign sum = {1'b0, credit} + val;
  assign ok  = (coin_val != CODE_INV) && (sum <= MAX_X) && !cancel;

  // Next state, next credit and next pulse outputs.
  always_comb begin
    state_n  = state;
    credit_n = credit;
    amt_n    = '0;
    coin_n   = 1'b0;
    check_n  = 1'b0;
    reject_n = 1'b0;
    refund_n = 1'b0;
    unique case (state)
      IDLE, COLLECT: begin
        if (accept) begin
          if (ok) begin
            coin_n   = 1'b1;
            credit_n = sum[W-1:0];
            if (sum >= PRICE_X) begin
              check_n = 1'b1;
              state_n = READY;
            end else begin
              state_n = COLLECT;
            end
          end else begin
            reject_n = 1'b1;
          end
        end
        if (state == COLLECT && cancel) begin
          state_n  = REFUND;
          refund_n = 1'b1;
          amt_n    = credit;
          credit_n = '0;
        end
      end
      READY: begin
        reject_n = accept;
        if (vend_done) begin
          credit_n = '0;
          if (credit > PRICE_W) begin
            state_n  = REFUND;
            refund_n = 1'b1;
            amt_n    = credit - PRICE_W;
          end else begin
            state_n = IDLE;
          end
        end
      end
      REFUND: begin
        reject_n = accept;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // State, credit and all outputs are registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      credit     <= '0;
      refund_amt <= '0;
      coin       <= 1'b0;
      check      <= 1'b0;
      reject     <= 1'b0;
      refund     <= 1'b0;
    end else begin
      state      <= state_n;
      credit     <= credit_n;
      refund_amt <= amt_n;
      coin       <= coin_n;
      check      <= check_n;
      reject     <= reject_n;
      refund     <= refund_n;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor.
// Expected pulse events are queued at stimulus time and popped on output.
module tb_coin_acceptor;
  import vend_pkg::*;

  typedef struct packed {
    logic       coin;
    logic       check;
    logic       reject;
    logic       refund;
    logic [7:0] credit;
    logic [7:0] amt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en2 = 1'b0;
  logic       rst2;
  logic       coin_raw = 1'b0;
  logic [1:0] coin_val = 2'b00;
  logic       cancel = 1'b0;
  logic       vend_done = 1'b0;

  logic       coin1, check1, reject1, refund1;
  logic [7:0] credit1, amt1;
  logic       coin2, check2, reject2, refund2;
  logic [7:0] credit2, amt2;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int coin_cyc = 0;
  int drive_cyc = 0;

  ev_t q1[$];
  ev_t q2[$];

  assign rst2 = rst & en2;

  coin_acceptor dut1 (
    .clk        (clk),
    .rst        (rst),
    .coin_raw   (coin_raw),
    .coin_val   (coin_val),
    .cancel     (cancel),
    .vend_done  (vend_done),
    .coin       (coin1),
    .check      (check1),
    .reject     (reject1),
    .credit     (credit1),
    .refund     (refund1),
    .refund_amt (amt1)
  );

  coin_acceptor #(.MAX_CREDIT(30)) dut2 (
    .clk        (clk),
    .rst        (rst2),
    .coin_raw   (coin_raw),
    .coin_val   (coin_val),
    .cancel     (cancel),
    .vend_done  (vend_done),
    .coin       (coin2),
    .check      (check2),
    .reject     (reject2),
    .credit     (credit2),
    .refund     (refund2),
    .refund_amt (amt2)
  );

  always #5 clk = ~clk;

  // Rising-edge counter for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic ev_t ev(input logic c, input logic k,
                             input logic r, input logic f,
                             input logic [7:0] cr, input logic [7:0] a);
    ev_t e;
    e.coin   = c;
    e.check  = k;
    e.reject = r;
    e.refund = f;
    e.credit = cr;
    e.amt    = a;
    return e;
  endfunction

  // Scoreboard for the default-parameter instance.
  always @(negedge clk) begin
    ev_t e;
    if (coin1) coin_cyc = cyc;
    if (coin1 | check1 | reject1 | refund1) begin
      if (q1.size() == 0) begin
        chk("q1 unexpected pulse",
            32'({coin1, check1, reject1, refund1}), 0);
      end else begin
        e = q1.pop_front();
        chk("q1 coin", 32'(coin1), 32'(e.coin));
        chk("q1 check", 32'(check1), 32'(e.check));
        chk("q1 reject", 32'(reject1), 32'(e.reject));
        chk("q1 refund", 32'(refund1), 32'(e.refund));
        chk("q1 credit", 32'(credit1), 32'(e.credit));
        chk("q1 refund_amt", 32'(amt1), 32'(e.amt));
      end
    end
  end

  // Scoreboard for the MAX_CREDIT=30 instance.
  always @(negedge clk) begin
    ev_t e;
    if (coin2 | check2 | reject2 | refund2) begin
      if (q2.size() == 0) begin
        chk("q2 unexpected pulse",
            32'({coin2, check2, reject2, refund2}), 0);
      end else begin
        e = q2.pop_front();
        chk("q2 coin", 32'(coin2), 32'(e.coin));
        chk("q2 reject", 32'(reject2), 32'(e.reject));
        chk("q2 credit", 32'(credit2), 32'(e.credit));
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic insert(input logic [1:0] code);
    coin_val  = code;
    coin_raw  = 1'b1;
    drive_cyc = cyc;
    idle(8);
    coin_raw = 1'b0;
    idle(8);
  endtask

  task automatic glitch(input int n);
    coin_raw = 1'b1;
    idle(n);
    coin_raw = 1'b0;
    idle(8);
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    idle(1);
    cancel = 1'b0;
  endtask

  task automatic do_vend();
    vend_done = 1'b1;
    idle(1);
    vend_done = 1'b0;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((q1.size() != 0 || q2.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("queue drain", 32'(q1.size() + q2.size()), 0);
  endtask

  initial begin
    idle(3);
    chk("reset credit", 32'(credit1), 0);
    chk("reset pulses", 32'({coin1, check1, reject1, refund1}), 0);
    chk("reset refund_amt", 32'(amt1), 0);
    chk("reset state", 32'(dut1.state), 32'(IDLE));
    rst = 1'b1;
    idle(10);

    // Three 25s reach the price; exact vend gives no refund.
    q1.push_back(ev(1, 0, 0, 0, 8'd25, 8'd0));
    insert(CODE_25);
    chk("coin latency edges", 32'(coin_cyc - drive_cyc), 7);
    q1.push_back(ev(1, 0, 0, 0, 8'd50, 8'd0));
    insert(CODE_25);
    q1.push_back(ev(1, 1, 0, 0, 8'd75, 8'd0));
    insert(CODE_25);
    drain(20);
    chk("ready state", 32'(dut1.state), 32'(READY));
    do_vend();
    idle(2);
    chk("exact vend credit", 32'(credit1), 0);
    chk("exact vend state", 32'(dut1.state), 32'(IDLE));

    // Short glitches are filtered; a bounce inside a coin counts once.
    glitch(2);
    glitch(3);
    chk("glitch credit", 32'(credit1), 0);
    q1.push_back(ev(1, 0, 0, 0, 8'd25, 8'd0));
    coin_val = CODE_25;
    glitch(0);
    coin_raw = 1'b1;
    idle(3);
    coin_raw = 1'b0;
    idle(1);
    insert(CODE_25);
    drain(20);
    chk("bounce credit", 32'(credit1), 25);
    q1.push_back(ev(0, 0, 0, 1, 8'd0, 8'd25));
    do_cancel();
    idle(2);

    // 25+25+10 then cancel refunds 60.
    q1.push_back(ev(1, 0, 0, 0, 8'd25, 8'd0));
    insert(CODE_25);
    q1.push_back(ev(1, 0, 0, 0, 8'd50, 8'd0));
    insert(CODE_25);
    q1.push_back(ev(1, 0, 0, 0, 8'd60, 8'd0));
    insert(CODE_10);
    q1.push_back(ev(0, 0, 0, 1, 8'd0, 8'd60));
    do_cancel();
    idle(1);
    chk("after refund state", 32'(dut1.state), 32'(IDLE));
    chk("after refund amt", 32'(amt1), 0);

    // 85 credit, extra coin rejected in READY, vend returns 10.
    q1.push_back(ev(1, 0, 0, 0, 8'd25, 8'd0));
    insert(CODE_25);
    q1.push_back(ev(1, 0, 0, 0, 8'd50, 8'd0));
    insert(CODE_25);
    q1.push_back(ev(1, 0, 0, 0, 8'd60, 8'd0));
    insert(CODE_10);
    q1.push_back(ev(1, 1, 0, 0, 8'd85, 8'd0));
    insert(CODE_25);
    q1.push_back(ev(0, 0, 1, 0, 8'd85, 8'd0));
    insert(CODE_10);
    q1.push_back(ev(0, 0, 0, 1, 8'd0, 8'd10));
    do_vend();
    idle(2);
    drain(20);
    chk("change state", 32'(dut1.state), 32'(IDLE));

    // Invalid code is rejected without credit.
    q1.push_back(ev(0, 0, 1, 0, 8'd0, 8'd0));
    insert(CODE_INV);
    drain(20);
    chk("invalid credit", 32'(credit1), 0);

    // Reset mid-debounce drops credit and the pending coin.
    q1.push_back(ev(1, 0, 0, 0, 8'd25, 8'd0));
    insert(CODE_25);
    q1.push_back(ev(1, 0, 0, 0, 8'd50, 8'd0));
    insert(CODE_25);
    drain(20);
    coin_val = CODE_25;
    coin_raw = 1'b1;
    idle(2);
    rst = 1'b0;
    idle(2);
    chk("mid reset credit", 32'(credit1), 0);
    chk("mid reset state", 32'(dut1.state), 32'(IDLE));
    coin_raw = 1'b0;
    rst = 1'b1;
    idle(10);
    chk("post reset credit", 32'(credit1), 0);
    q1.push_back(ev(1, 0, 0, 0, 8'd25, 8'd0));
    insert(CODE_25);
    drain(20);

    // Ceiling of 30: 25 accepted, 10 rejected on the second instance.
    rst = 1'b0;
    idle(1);
    en2 = 1'b1;
    idle(1);
    rst = 1'b1;
    idle(10);
    q1.push_back(ev(1, 0, 0, 0, 8'd25, 8'd0));
    q2.push_back(ev(1, 0, 0, 0, 8'd25, 8'd0));
    insert(CODE_25);
    q1.push_back(ev(1, 0, 0, 0, 8'd35, 8'd0));
    q2.push_back(ev(0, 0, 1, 0, 8'd25, 8'd0));
    insert(CODE_10);
    drain(20);
    chk("max credit hold", 32'(credit2), 25);
    chk("max credit main", 32'(credit1), 35);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
